// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states and the alignment rule.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    DONE     = 2'd2,
    DONE_ERR = 2'd3
  } state_e;

  // Size 2'b11 falls through to the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == SZ_BYTE) return 1'b0;
    if (size == SZ_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, replicated store data and extended load data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = load_word[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = load_word[gi*16 +: 16];
    end
  endgenerate

  assign byte_sel = byte_lane[off];
  assign half_sel = half_lane[off[1]];

  always_comb begin
    be          = 4'b1111;
    store_lanes = store_data;
    load_data   = load_word;
    case (size)
      SZ_BYTE: begin
        be          = 4'b0001 << off;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be          = 4'b0011 << off;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{sign_ext & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: runs one load/store at a time over a req/ack data port,
// stalling upstream until the access completes and presenting a bubble meanwhile.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic [31:0] ALUOutOut,
  output logic [31:0] DATA,
  output logic [4:0]  WriteRegOut,
  output logic        StallM,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

  state_e state_reg, state_next;

  logic [31:0]      addr_reg, wdata_reg, load_reg;
  logic [3:0]       be_reg;
  logic [1:0]       size_reg;
  logic             we_reg, signed_reg, regwrite_reg, memtoreg_reg;
  logic [4:0]       writereg_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic        access, misaligned, start;
  logic        stall, align_err, bus_err, req;
  logic        rw_out, m2r_out;
  logic [31:0] alu_out, data_out;
  logic [4:0]  wr_out;

  logic        in_idle;
  logic [1:0]  size_sel, off_sel;
  logic        signed_sel;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = is_misaligned(MemSizeM, ALUOutM[1:0]);

  // One aligner serves the store path from the live inputs in IDLE and
  // the load path from the latched controls once the access is in flight.
  assign in_idle    = (state_reg == IDLE);
  assign size_sel   = in_idle ? MemSizeM      : size_reg;
  assign off_sel    = in_idle ? ALUOutM[1:0]  : addr_reg[1:0];
  assign signed_sel = in_idle ? MemSignedM    : signed_reg;

  mem_lane_align u_align (
    .size        (size_sel),
    .sign_ext    (signed_sel),
    .off         (off_sel),
    .store_data  (WriteDataM),
    .load_word   (mem_rdata),
    .be          (lane_be),
    .store_lanes (lane_wdata),
    .load_data   (lane_load)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    stall      = 1'b0;
    align_err  = 1'b0;
    bus_err    = 1'b0;
    req        = 1'b0;
    rw_out     = 1'b0;
    m2r_out    = 1'b0;
    alu_out    = '0;
    data_out   = '0;
    wr_out     = '0;
    case (state_reg)
      IDLE: begin
        if (!access) begin
          rw_out  = RegWriteM;
          m2r_out = MemtoRegM;
          alu_out = ALUOutM;
          wr_out  = WriteRegM;
        end else if (misaligned) begin
          align_err = 1'b1;
        end else begin
          stall      = 1'b1;
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem_ack) begin
          state_next = DONE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_reg == TIMEOUT_VAL)) begin
          bus_err    = 1'b1;
          state_next = DONE_ERR;
        end
      end
      DONE, DONE_ERR: begin
        rw_out     = (state_reg == DONE) ? regwrite_reg : 1'b0;
        m2r_out    = memtoreg_reg;
        alu_out    = addr_reg;
        wr_out     = writereg_reg;
        data_out   = load_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_reg     <= '0;
      wdata_reg    <= '0;
      load_reg     <= '0;
      be_reg       <= '0;
      size_reg     <= '0;
      we_reg       <= 1'b0;
      signed_reg   <= 1'b0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      writereg_reg <= '0;
      cnt_reg      <= '0;
    end else if (start) begin
      addr_reg     <= ALUOutM;
      wdata_reg    <= lane_wdata;
      be_reg       <= lane_be;
      size_reg     <= MemSizeM;
      we_reg       <= MemWriteM;
      signed_reg   <= MemSignedM;
      regwrite_reg <= RegWriteM;
      memtoreg_reg <= MemtoRegM;
      writereg_reg <= WriteRegM;
      load_reg     <= '0;
      cnt_reg      <= '0;
    end else if (state_reg == BUSY) begin
      if (mem_ack) load_reg <= we_reg ? 32'd0 : lane_load;
      else         cnt_reg  <= cnt_reg + 1'b1;
    end
  end

  // Reset forces every output low combinationally so mem_req drops at once.
  assign RegWriteOut = rw_out & ~RESET;
  assign MemtoRegOut = m2r_out & ~RESET;
  assign ALUOutOut   = RESET ? 32'd0 : alu_out;
  assign DATA        = RESET ? 32'd0 : data_out;
  assign WriteRegOut = RESET ? 5'd0 : wr_out;
  assign StallM      = stall & ~RESET;
  assign AlignErr    = align_err & ~RESET;
  assign BusErr      = bus_err & ~RESET;
  assign mem_req     = req & ~RESET;
  assign mem_we      = mem_req & we_reg;
  assign mem_addr    = mem_req ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign mem_be      = mem_req ? be_reg : 4'd0;
  assign mem_wdata   = mem_req ? wdata_reg : 32'd0;

endmodule
